// File: rtl/hazard_controller_if.sv
// Control bundle between the pipeline datapath (master) and the hazard controller (slave).
// The datapath drives the D-stage decode fields and branch outcome; the controller drives the stall, flush and forward controls.
interface hazard_controller_if;
    logic [4:0] d_rs1;
    logic [4:0] d_rs2;
    logic [4:0] d_rd;
    logic       d_reg_write;
    logic       d_is_load;
    logic       d_is_multicycle;
    logic       d_is_jump;
    logic       d_valid;
    logic       e_take_branch;

    logic       f_stall;
    logic       d_stall;
    logic       d_flush;
    logic       e_stall;
    logic       e_flush;
    logic       m_flush;
    logic [1:0] e_forward_a;
    logic [1:0] e_forward_b;
    logic       e_pc_src;

    modport master (
        output d_rs1, d_rs2, d_rd, d_reg_write, d_is_load, d_is_multicycle,
               d_is_jump, d_valid, e_take_branch,
        input  f_stall, d_stall, d_flush, e_stall, e_flush, m_flush,
               e_forward_a, e_forward_b, e_pc_src
    );

    modport slave (
        input  d_rs1, d_rs2, d_rd, d_reg_write, d_is_load, d_is_multicycle,
               d_is_jump, d_valid, e_take_branch,
        output f_stall, d_stall, d_flush, e_stall, e_flush, m_flush,
               e_forward_a, e_forward_b, e_pc_src
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage core: shadows E/M/W destination state and
// produces forwarding selects, load-use stalls, redirect flushes and multi-cycle Execute stalls.
module hazard_controller #(
    parameter int MC_LATENCY = 4
) (
    input  logic                clk,
    input  logic                reset,
    hazard_controller_if.slave  hz
);
    localparam int             CW      = $clog2(MC_LATENCY) + 1;
    localparam logic [CW-1:0]  MC_LAST = CW'(MC_LATENCY - 1);

    logic [4:0]    r_e_rs1, r_e_rs2, r_e_rd;
    logic          r_e_reg_write, r_e_load, r_e_mc, r_e_jump, r_e_valid;
    logic [4:0]    r_m_rd;
    logic          r_m_reg_write, r_m_load;
    logic [4:0]    r_w_rd;
    logic          r_w_reg_write;
    logic [CW-1:0] r_mc_count;

    logic w_busy, w_redirect, w_load_use;
    logic w_f_stall, w_d_stall, w_d_flush, w_e_stall, w_e_flush, w_m_flush, w_pc_src;
    logic [1:0] w_fwd_a, w_fwd_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_rs1       <= '0;
            r_e_rs2       <= '0;
            r_e_rd        <= '0;
            r_e_reg_write <= 1'b0;
            r_e_load      <= 1'b0;
            r_e_mc        <= 1'b0;
            r_e_jump      <= 1'b0;
            r_e_valid     <= 1'b0;
            r_mc_count    <= '0;
            r_m_rd        <= '0;
            r_m_reg_write <= 1'b0;
            r_m_load      <= 1'b0;
            r_w_rd        <= '0;
            r_w_reg_write <= 1'b0;
        end else begin
            // A held multi-cycle op counts the cycles it has already spent in E.
            if (w_e_stall) begin
                r_mc_count <= r_mc_count + CW'(1);
            end else if (w_e_flush) begin
                r_e_rs1       <= '0;
                r_e_rs2       <= '0;
                r_e_rd        <= '0;
                r_e_reg_write <= 1'b0;
                r_e_load      <= 1'b0;
                r_e_mc        <= 1'b0;
                r_e_jump      <= 1'b0;
                r_e_valid     <= 1'b0;
                r_mc_count    <= '0;
            end else begin
                r_e_rs1       <= hz.d_rs1;
                r_e_rs2       <= hz.d_rs2;
                r_e_rd        <= hz.d_rd;
                r_e_reg_write <= hz.d_reg_write;
                r_e_load      <= hz.d_is_load;
                r_e_mc        <= hz.d_is_multicycle;
                r_e_jump      <= hz.d_is_jump;
                r_e_valid     <= hz.d_valid;
                r_mc_count    <= '0;
            end

            if (w_m_flush) begin
                r_m_rd        <= '0;
                r_m_reg_write <= 1'b0;
                r_m_load      <= 1'b0;
            end else begin
                r_m_rd        <= r_e_rd;
                r_m_reg_write <= r_e_reg_write;
                r_m_load      <= r_e_load;
            end

            r_w_rd        <= r_m_rd;
            r_w_reg_write <= r_m_reg_write;
        end
    end

    assign w_busy     = r_e_valid & r_e_mc & (r_mc_count < MC_LAST);
    assign w_redirect = r_e_valid & ~w_busy & (r_e_jump | hz.e_take_branch);
    assign w_load_use = r_e_valid & r_e_load & (r_e_rd != 5'd0) & hz.d_valid &
                        ((hz.d_rs1 == r_e_rd) | (hz.d_rs2 == r_e_rd));

    always_comb begin
        w_f_stall = 1'b0;
        w_d_stall = 1'b0;
        w_d_flush = 1'b0;
        w_e_stall = 1'b0;
        w_e_flush = 1'b0;
        w_m_flush = 1'b0;
        w_pc_src  = 1'b0;
        if (w_busy) begin
            w_f_stall = 1'b1;
            w_d_stall = 1'b1;
            w_e_stall = 1'b1;
            w_m_flush = 1'b1;
        end else if (w_redirect) begin
            w_pc_src  = 1'b1;
            w_d_flush = 1'b1;
            w_e_flush = 1'b1;
        end else if (w_load_use) begin
            w_f_stall = 1'b1;
            w_d_stall = 1'b1;
            w_e_flush = 1'b1;
        end
    end

    // Newest producer wins; x0 is hard-wired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (r_m_reg_write && (r_m_rd != 5'd0) && (r_m_rd == src))
            return 2'b10;
        else if (r_w_reg_write && (r_w_rd != 5'd0) && (r_w_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_fwd_a = fwd_sel(r_e_rs1);
    assign w_fwd_b = fwd_sel(r_e_rs2);

    assign hz.f_stall     = w_f_stall;
    assign hz.d_stall     = w_d_stall;
    assign hz.d_flush     = w_d_flush;
    assign hz.e_stall     = w_e_stall;
    assign hz.e_flush     = w_e_flush;
    assign hz.m_flush     = w_m_flush;
    assign hz.e_pc_src    = w_pc_src;
    assign hz.e_forward_a = w_fwd_a;
    assign hz.e_forward_b = w_fwd_b;
endmodule
